// File: rtl/request_capture8_pkg.sv
// Shared widths and priority helpers for the request capture front end
// and the 8-to-3 encoder stage that consumes its offers.
package request_capture8_pkg;

    localparam int REQ_WIDTH  = 8;
    localparam int CODE_WIDTH = 3;

    // Later set bits overwrite earlier ones, so scan order decides priority.
    function automatic logic [REQ_WIDTH-1:0] prio_sel(
        input logic [REQ_WIDTH-1:0] vec,
        input logic                 high_first
    );
        logic [REQ_WIDTH-1:0] sel;
        sel = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (high_first) begin
                if (vec[i]) sel = REQ_WIDTH'(1) << i;
            end else begin
                if (vec[REQ_WIDTH-1-i]) sel = REQ_WIDTH'(1) << (REQ_WIDTH-1-i);
            end
        end
        return sel;
    endfunction

    function automatic logic [CODE_WIDTH-1:0] onehot_to_code(
        input logic [REQ_WIDTH-1:0] onehot
    );
        logic [CODE_WIDTH-1:0] code;
        code = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (onehot[i]) code = code | CODE_WIDTH'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/request_capture8_sync_edge_detect.sv
// Per-line synchroniser chain plus previous-value register;
// emits a one-cycle rise for every synchronised 0->1 transition.
module sync_edge_detect #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) chain[s] <= '0;
            prev <= '0;
        end else begin
            chain[0] <= req_in;
            for (int s = 1; s < SYNC_STAGES; s++) chain[s] <= chain[s-1];
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/request_capture8.sv
// Captures rising request edges as pending bits and offers the
// highest-priority unmasked one as a registered one-hot word plus code.
module request_capture8
    import request_capture8_pkg::*;
#(
    parameter int WIDTH       = REQ_WIDTH,
    parameter int CODE_W      = CODE_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter bit HIGH_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  req_in,
    input  logic [WIDTH-1:0]  mask,
    output logic [WIDTH-1:0]  out_onehot,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  pending,
    output logic              overflow
);

    logic [WIDTH-1:0] rise;
    logic             acc;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] sel;
    logic             load;

    sync_edge_detect #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .req_in (req_in),
        .rise   (rise)
    );

    assign acc  = out_valid & out_ready;
    assign clr  = acc ? out_onehot : '0;
    assign cand = pending & ~mask & ~clr;
    assign sel  = prio_sel(cand, HIGH_FIRST);
    // Only refill when empty or just consumed, so a stalled offer never changes.
    assign load = ~out_valid | acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_code   <= '0;
        end else begin
            pending  <= (pending & ~clr) | rise;
            overflow <= |(rise & pending & ~clr);
            if (load) begin
                out_valid  <= |cand;
                out_onehot <= sel;
                out_code   <= onehot_to_code(sel);
            end
        end
    end

endmodule

// File: tb/tb_request_capture8.sv
// Directed bench for request_capture8: reset, latency, priority,
// stall stability, overflow, masking and reset during an offer.
module tb_request_capture8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic [7:0] out_onehot;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    request_capture8 dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .mask       (mask),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input string tag, input logic v,
                         input logic [7:0] oh, input logic [2:0] c);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_onehot"}, 32'(out_onehot), 32'(oh));
        check({tag, "_code"}, 32'(out_code), 32'(c));
    endtask

    task automatic drain(input string tag);
        req_in    = 8'h00;
        mask      = 8'h00;
        out_ready = 1'b1;
        step(16);
        check({tag, "_pend"}, 32'(pending), 32'h0);
        check({tag, "_valid"}, 32'(out_valid), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        req_in    = 8'hFF;
        mask      = 8'h00;
        out_ready = 1'b0;

        // 1: reset with all lines high
        step(1);
        offer("rst1", 1'b0, 8'h00, 3'd0);
        check("rst1_pend", 32'(pending), 32'h0);
        check("rst1_ovf", 32'(overflow), 32'h0);
        step(1);
        offer("rst2", 1'b0, 8'h00, 3'd0);
        rst = 1'b0;
        step(3);
        check("lat1_early", 32'(out_valid), 32'h0);
        check("lat1_pend", 32'(pending), 32'hFF);
        step(1);
        offer("lat1", 1'b1, 8'h80, 3'd7);
        drain("dr1");

        // 2: single request, no refire while held
        req_in    = 8'h04;
        out_ready = 1'b1;
        step(3);
        check("sgl_early", 32'(out_valid), 32'h0);
        step(1);
        offer("sgl", 1'b1, 8'h04, 3'd2);
        step(1);
        check("sgl_done", 32'(out_valid), 32'h0);
        check("sgl_pend", 32'(pending), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("sgl_norefire", 32'(out_valid | |pending), 32'h0);
        end
        drain("dr2");

        // 3: priority and stall
        req_in    = 8'h81;
        out_ready = 1'b0;
        step(4);
        for (int i = 0; i < 10; i++) begin
            offer("stall", 1'b1, 8'h80, 3'd7);
            step(1);
        end
        check("stall_pend", 32'(pending), 32'h81);
        out_ready = 1'b1;
        step(1);
        offer("pri_lo", 1'b1, 8'h01, 3'd0);
        step(1);
        offer("pri_end", 1'b0, 8'h00, 3'd0);
        drain("dr3");

        // 4: duplicate edge while pending
        out_ready = 1'b0;
        req_in    = 8'h08;
        step(2);
        req_in = 8'h00;
        step(2);
        req_in = 8'h08;
        step(2);
        check("ovf_pre", 32'(overflow), 32'h0);
        offer("ovf_off", 1'b1, 8'h08, 3'd3);
        step(1);
        check("ovf_hit", 32'(overflow), 32'h1);
        step(1);
        check("ovf_post", 32'(overflow), 32'h0);
        out_ready = 1'b1;
        step(1);
        check("ovf_grant", 32'(out_valid), 32'h0);
        check("ovf_pend", 32'(pending), 32'h0);
        step(3);
        check("ovf_once", 32'(out_valid), 32'h0);
        drain("dr4");

        // 5: masked bit stays pending
        mask      = 8'h80;
        req_in    = 8'h90;
        out_ready = 1'b1;
        step(4);
        offer("msk", 1'b1, 8'h10, 3'd4);
        check("msk_pend", 32'(pending), 32'h90);
        step(1);
        check("msk_hold", 32'(out_valid), 32'h0);
        check("msk_pend2", 32'(pending), 32'h80);
        mask = 8'h00;
        step(1);
        offer("unmsk", 1'b1, 8'h80, 3'd7);
        step(1);
        check("unmsk_done", 32'(out_valid | |pending), 32'h0);
        drain("dr5");

        // 6: reset during a stalled offer
        req_in    = 8'hA0;
        out_ready = 1'b0;
        step(4);
        offer("mid", 1'b1, 8'h80, 3'd7);
        rst = 1'b1;
        step(1);
        offer("mid_rst", 1'b0, 8'h00, 3'd0);
        check("mid_pend", 32'(pending), 32'h0);
        rst = 1'b0;
        step(3);
        check("mid_early", 32'(out_valid), 32'h0);
        step(1);
        offer("mid_again", 1'b1, 8'h80, 3'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got 1 want 0");
        $fatal(1);
    end

endmodule
